// File: rtl/sub_bytes_iter_if.sv
// Valid/ready handshake bundle between the SubBytes stage, its producer and shift_rows.
// The slave modport is the SubBytes side; the master modport is the driver/consumer side.
interface sub_bytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/sub_bytes_iter.sv
// Iterative AES forward SubBytes: substitutes SBOX_LANES bytes per cycle through shared
// S-box lanes and holds the result on out_state until the downstream stage takes it.
module sub_bytes_iter #(
  parameter int SBOX_LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sub_bytes_iter_if.slave  bus
);

  localparam int STEPS = 16 / SBOX_LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
      SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_iter: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 forward S-box; element 0 is the leftmost entry.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [1:0]                  r_state;
  logic [CNT_W-1:0]            r_cnt;
  // Packed index 15 is byte0 ([127:120]), so byte k lives at r_work[15-k].
  logic [15:0][7:0]            r_work;
  logic                        r_out_valid;
  logic [15:0][7:0]            w_work_next;
  logic [SBOX_LANES-1:0][7:0]  w_lane_in;
  logic [SBOX_LANES-1:0][7:0]  w_lane_out;

  // NOTE: every always_comb output gets a full default first so no path can infer a latch.
  always_comb begin
    w_lane_in = '0;
    for (int s = 0; s < STEPS; s++) begin
      if (r_cnt == CNT_W'(s)) begin
        for (int j = 0; j < SBOX_LANES; j++) begin
          w_lane_in[j] = r_work[15 - (s * SBOX_LANES + j)];
        end
      end
    end
  end

  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
    assign w_lane_out[j] = SBOX[w_lane_in[j]];
  end

  // Only the group selected by r_cnt is rewritten; all other bytes pass through unchanged.
  always_comb begin
    w_work_next = r_work;
    for (int s = 0; s < STEPS; s++) begin
      if (r_cnt == CNT_W'(s)) begin
        for (int j = 0; j < SBOX_LANES; j++) begin
          w_work_next[15 - (s * SBOX_LANES + j)] = w_lane_out[j];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the work register is reset as well, because it drives out_state directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_work  <= bus.in_state;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_state = r_work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: FIPS-197 vectors, latency per lane count,
// back-pressure, mid-run reset and back-to-back handshakes.
module tb_sub_bytes_iter;

  localparam logic [127:0] V_SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V_SEQ_OUT  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] V_APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V_APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V_ZERO_OUT = {16{8'h63}};
  localparam logic [127:0] V_ONES_IN  = {16{8'hff}};
  localparam logic [127:0] V_ONES_OUT = {16{8'h16}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sub_bytes_iter_if bus4 ();
  sub_bytes_iter_if bus1 ();
  sub_bytes_iter_if bus2 ();
  sub_bytes_iter_if bus8 ();
  sub_bytes_iter_if bus16 ();

  sub_bytes_iter #(.SBOX_LANES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  sub_bytes_iter #(.SBOX_LANES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  sub_bytes_iter #(.SBOX_LANES(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  sub_bytes_iter #(.SBOX_LANES(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  sub_bytes_iter #(.SBOX_LANES(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid on the L=4 instance; a timeout is recorded as a failure.
  task automatic wait_valid4(input string tag, output int n);
    n = 0;
    while (!bus4.out_valid && n < 40) begin
      step();
      n++;
    end
    if (!bus4.out_valid) check({tag, " timeout"}, 128'd0, 128'd1);
  endtask

  // Accept din on the next edge, check latency and result, then hand it off.
  task automatic run4(input string tag, input logic [127:0] din, input logic [127:0] dexp);
    int n;
    bus4.in_valid = 1'b1;
    bus4.in_state = din;
    step();
    bus4.in_valid = 1'b0;
    bus4.in_state = '0;
    check({tag, " busy"}, bus4.busy, 1'b1);
    wait_valid4(tag, n);
    check({tag, " latency"}, n, 4);
    check({tag, " out_state"}, bus4.out_state, dexp);
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    check({tag, " drop valid"}, bus4.out_valid, 1'b0);
    check({tag, " idle ready"}, bus4.in_ready, 1'b1);
  endtask

  initial begin
    int lat1, lat2, lat8, lat16, n;
    logic [127:0] held;

    bus4.in_valid = 1'b0;  bus4.in_state = '0;  bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0;  bus1.in_state = '0;  bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0;  bus2.in_state = '0;  bus2.out_ready = 1'b0;
    bus8.in_valid = 1'b0;  bus8.in_state = '0;  bus8.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_state = '0; bus16.out_ready = 1'b0;

    #12;
    check("reset out_valid", bus4.out_valid, 1'b0);
    check("reset busy", bus4.busy, 1'b0);
    check("reset out_state", bus4.out_state, 128'd0);
    check("reset in_ready", bus4.in_ready, 1'b1);
    rst_n = 1'b1;
    step();
    check("post-reset in_ready", bus4.in_ready, 1'b1);

    // Main function on several patterns.
    run4("appB", V_APPB_IN, V_APPB_OUT);
    run4("zero", 128'd0, V_ZERO_OUT);
    run4("seq", V_SEQ_IN, V_SEQ_OUT);
    run4("ones", V_ONES_IN, V_ONES_OUT);

    // out_ready withheld in DONE; a competing in_valid must be ignored.
    bus4.in_valid = 1'b1;
    bus4.in_state = V_APPB_IN;
    step();
    bus4.in_state = V_SEQ_IN;
    wait_valid4("hold", n);
    held = bus4.out_state;
    check("hold first result", held, V_APPB_OUT);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold out_valid", bus4.out_valid, 1'b1);
      check("hold out_state", bus4.out_state, V_APPB_OUT);
      check("hold in_ready", bus4.in_ready, 1'b0);
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    check("hold release valid", bus4.out_valid, 1'b0);
    check("hold release ready", bus4.in_ready, 1'b1);
    check("hold release busy", bus4.busy, 1'b0);

    // Reset in the middle of RUN.
    bus4.in_valid = 1'b1;
    bus4.in_state = V_APPB_IN;
    step();
    bus4.in_valid = 1'b0;
    step();
    step();
    check("pre-reset busy", bus4.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrun out_valid", bus4.out_valid, 1'b0);
    check("midrun busy", bus4.busy, 1'b0);
    check("midrun out_state", bus4.out_state, 128'd0);
    check("midrun in_ready", bus4.in_ready, 1'b1);
    #3;
    rst_n = 1'b1;
    step();
    run4("after reset", V_SEQ_IN, V_SEQ_OUT);

    // Back-to-back: in_valid stays high across two states.
    bus4.in_valid = 1'b1;
    bus4.in_state = V_SEQ_IN;
    step();
    bus4.in_state = V_APPB_IN;
    wait_valid4("b2b first", n);
    check("b2b first latency", n, 4);
    check("b2b first result", bus4.out_state, V_SEQ_OUT);
    step();
    step();
    check("b2b no early capture", bus4.out_state, V_SEQ_OUT);
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    check("b2b idle gap ready", bus4.in_ready, 1'b1);
    step();
    bus4.in_valid = 1'b0;
    check("b2b second accepted", bus4.busy, 1'b1);
    wait_valid4("b2b second", n);
    check("b2b second latency", n, 4);
    check("b2b second result", bus4.out_state, V_APPB_OUT);
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;

    // Other lane counts in parallel: latency 16, 8, 2 and 1.
    bus1.in_valid = 1'b1;  bus1.in_state = V_SEQ_IN;
    bus2.in_valid = 1'b1;  bus2.in_state = V_SEQ_IN;
    bus8.in_valid = 1'b1;  bus8.in_state = V_SEQ_IN;
    bus16.in_valid = 1'b1; bus16.in_state = V_SEQ_IN;
    step();
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
    bus16.in_valid = 1'b0;
    lat1 = -1; lat2 = -1; lat8 = -1; lat16 = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus1.out_valid && lat1 < 0) lat1 = i;
      if (bus2.out_valid && lat2 < 0) lat2 = i;
      if (bus8.out_valid && lat8 < 0) lat8 = i;
      if (bus16.out_valid && lat16 < 0) lat16 = i;
    end
    check("L1 latency", lat1, 16);
    check("L2 latency", lat2, 8);
    check("L8 latency", lat8, 2);
    check("L16 latency", lat16, 1);
    check("L1 result", bus1.out_state, V_SEQ_OUT);
    check("L2 result", bus2.out_state, V_SEQ_OUT);
    check("L8 result", bus8.out_state, V_SEQ_OUT);
    check("L16 result", bus16.out_state, V_SEQ_OUT);
    bus1.out_ready = 1'b1;
    bus16.out_ready = 1'b1;
    step();
    check("L1 release", bus1.in_ready, 1'b1);
    check("L16 release", bus16.in_ready, 1'b1);
    check("L2 still held", bus2.out_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
